// File: rtl/instr_cache_pkg.sv
// Shared widths and FSM encodings for the instruction cache.
// Imported by instr_cache and icache_lookup.
// No ports; constants and types only.
package instr_cache_pkg;

    localparam int VIRT_ADDR_WIDTH   = 32;
    localparam int ICACHE_LINE_WIDTH = 128;
    localparam int ICACHE_TAG_WIDTH  = 28;

    // Refill FSM; IDLE must stay 0 so the reset value is the idle state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } icache_state_t;

endpackage

// File: rtl/instr_cache_lookup.sv
// Combinational fully-associative tag compare plus 32-bit word select.
// Ports: i_valid/i_tags/i_lines (cache arrays), i_addr (addr[31:2]);
//        o_hit, o_hit_idx, o_instr (zero when no line matches).
module icache_lookup
    import instr_cache_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic [NUM_LINES-1:0]                        i_valid,
    input  logic [NUM_LINES-1:0][ICACHE_TAG_WIDTH-1:0]  i_tags,
    input  logic [NUM_LINES-1:0][ICACHE_LINE_WIDTH-1:0] i_lines,
    input  logic [VIRT_ADDR_WIDTH-1:2]                  i_addr,
    output logic                                        o_hit,
    output logic [IDX_W-1:0]                            o_hit_idx,
    output logic [31:0]                                 o_instr
);

    logic             w_hit;
    logic [IDX_W-1:0] w_idx;

    // A tag can live in at most one line (refills happen only on a miss),
    // so the last-match-wins loop never has to arbitrate.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (i_valid[i] && (i_tags[i] == i_addr[VIRT_ADDR_WIDTH-1:4])) begin
                w_hit = 1'b1;
                w_idx = i[IDX_W-1:0];
            end
        end
    end

    assign o_hit     = w_hit;
    assign o_hit_idx = w_idx;
    assign o_instr   = w_hit ? i_lines[w_idx][{i_addr[3:2], 5'd0} +: 32] : 32'd0;

endmodule

// File: rtl/instr_cache.sv
// Fully-associative instruction cache, FIFO replacement, single outstanding refill.
// Ports: clk/reset (sync, active-high); wrt_en, addr fetch side; data_to_fill,
//        mem_data_rdy, data_filled_ack from memory; instr, cache_hit, reqI_mem,
//        reqAddrI_mem out. Optional ICACHE_PERF_EN adds hit_count/miss_count.
module instr_cache
    import instr_cache_pkg::*;
#(
    parameter int NUM_LINES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wrt_en,
    input  logic [VIRT_ADDR_WIDTH-1:0]    addr,
    input  logic [ICACHE_LINE_WIDTH-1:0]  data_to_fill,
    input  logic                          mem_data_rdy,
    input  logic                          data_filled_ack,
    output logic [31:0]                   instr,
    output logic                          cache_hit,
    output logic                          reqI_mem,
    output logic [ICACHE_TAG_WIDTH-1:0]   reqAddrI_mem
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]                   hit_count,
    output logic [31:0]                   miss_count
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);

    icache_state_t                              r_state;
    icache_state_t                              w_state_nxt;
    logic [NUM_LINES-1:0]                       r_valid;
    logic [NUM_LINES-1:0][ICACHE_TAG_WIDTH-1:0] r_tags;
    logic [NUM_LINES-1:0][ICACHE_LINE_WIDTH-1:0] r_lines;
    logic [IDX_W-1:0]                           r_fifo_ptr;
    logic                                       r_req;
    logic [ICACHE_TAG_WIDTH-1:0]                r_req_addr;

    logic                                       w_lkp_hit;
    logic [IDX_W-1:0]                           w_lkp_idx;
    logic [31:0]                                w_lkp_instr;
    logic                                       w_idle;
    logic                                       w_issue;
    logic                                       w_fill;
    logic                                       w_unused_ok;

    // Byte offset within the word is deliberately ignored.
    assign w_unused_ok = &{1'b0, addr[1:0]};

    icache_lookup #(
        .NUM_LINES (NUM_LINES)
    ) u_lookup (
        .i_valid   (r_valid),
        .i_tags    (r_tags),
        .i_lines   (r_lines),
        .i_addr    (addr[VIRT_ADDR_WIDTH-1:2]),
        .o_hit     (w_lkp_hit),
        .o_hit_idx (w_lkp_idx),
        .o_instr   (w_lkp_instr)
    );

    assign w_idle    = (r_state == IDLE);
    assign w_issue   = w_idle && !w_lkp_hit && wrt_en;
    assign w_fill    = (r_state == REQ) && mem_data_rdy;
    // A hit is only reported while no refill is in flight.
    assign cache_hit = w_idle && w_lkp_hit;
    assign instr     = cache_hit ? w_lkp_instr : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_issue)         w_state_nxt = REQ;
            REQ:     if (mem_data_rdy)    w_state_nxt = ACK;
            ACK:     if (data_filled_ack) w_state_nxt = IDLE;
            default:                      w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= '0;
            r_fifo_ptr <= '0;
            r_req      <= 1'b0;
            r_req_addr <= '0;
        end else begin
            if (w_issue) begin
                r_req      <= 1'b1;
                r_req_addr <= addr[VIRT_ADDR_WIDTH-1:4];
            end else if (w_fill) begin
                r_req                <= 1'b0;
                r_valid[r_fifo_ptr]  <= 1'b1;
                r_tags[r_fifo_ptr]   <= r_req_addr;
                r_fifo_ptr           <= (r_fifo_ptr == IDX_W'(NUM_LINES - 1)) ? '0 : r_fifo_ptr + 1'b1;
            end
        end
    end

    // Line data has no reset; reset still blocks a same-cycle refill write.
    always_ff @(posedge clk) begin
        if (w_fill && !reset) begin
            r_lines[r_fifo_ptr] <= data_to_fill;
        end
    end

    assign reqI_mem     = r_req;
    assign reqAddrI_mem = r_req_addr;

`ifdef ICACHE_PERF_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (cache_hit && wrt_en) r_hit_count  <= r_hit_count + 32'd1;
            if (w_issue)             r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    // Counters are absent in this build.
`endif

endmodule

// File: tb/tb_instr_cache.sv
module tb_instr_cache;

    logic         clk = 1'b0;
    logic         reset;
    logic         wrt_en;
    logic [31:0]  addr;
    logic [127:0] data_to_fill;
    logic         mem_data_rdy;
    logic         data_filled_ack;
    logic [31:0]  instr;
    logic         cache_hit;
    logic         reqI_mem;
    logic [27:0]  reqAddrI_mem;
`ifdef ICACHE_PERF_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_cache #(.NUM_LINES(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .wrt_en          (wrt_en),
        .addr            (addr),
        .data_to_fill    (data_to_fill),
        .mem_data_rdy    (mem_data_rdy),
        .data_filled_ack (data_filled_ack),
        .instr           (instr),
        .cache_hit       (cache_hit),
        .reqI_mem        (reqI_mem),
        .reqAddrI_mem    (reqAddrI_mem)
`ifdef ICACHE_PERF_EN
        ,
        .hit_count       (hit_count),
        .miss_count      (miss_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk_line(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    // Miss on a, refill with d (one memory-latency cycle, one ACK cycle).
    task automatic fill(input logic [31:0] a, input logic [127:0] d);
        addr   = a;
        wrt_en = 1'b1;
        #1;
        chk("fill_miss", {31'd0, cache_hit}, 32'd0);
        step();
        chk("fill_req", {31'd0, reqI_mem}, 32'd1);
        chk("fill_req_addr", {4'd0, reqAddrI_mem}, {4'd0, a[31:4]});
        data_to_fill = d;
        mem_data_rdy = 1'b1;
        step();
        mem_data_rdy    = 1'b0;
        data_filled_ack = 1'b1;
        step();
        data_filled_ack = 1'b0;
        wrt_en          = 1'b0;
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        wrt_en          = 1'b0;
        addr            = 32'h0;
        data_to_fill    = '0;
        mem_data_rdy    = 1'b0;
        data_filled_ack = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;

        // Reset state
        chk("rst_req", {31'd0, reqI_mem}, 32'd0);
        chk("rst_req_addr", {4'd0, reqAddrI_mem}, 32'd0);
        chk("rst_hit", {31'd0, cache_hit}, 32'd0);
        chk("rst_instr", instr, 32'd0);

        // First miss and request
        addr   = 32'h0000_1000;
        wrt_en = 1'b1;
        #1;
        chk("miss_hit", {31'd0, cache_hit}, 32'd0);
        chk("miss_instr", instr, 32'd0);
        step();
        chk("req_issued", {31'd0, reqI_mem}, 32'd1);
        chk("req_addr", {4'd0, reqAddrI_mem}, 32'h0000_0100);

        // Address change while in REQ must not disturb the request
        addr = 32'h0000_9000;
        step();
        chk("req_hold", {31'd0, reqI_mem}, 32'd1);
        chk("req_addr_hold", {4'd0, reqAddrI_mem}, 32'h0000_0100);

        // Refill
        addr         = 32'h0000_1000;
        data_to_fill = 128'h44444444_33333333_22222222_11111111;
        mem_data_rdy = 1'b1;
        step();
        mem_data_rdy = 1'b0;
        chk("ack_req_clr", {31'd0, reqI_mem}, 32'd0);
        chk("ack_no_hit", {31'd0, cache_hit}, 32'd0);
        data_filled_ack = 1'b1;
        step();
        data_filled_ack = 1'b0;
        wrt_en          = 1'b0;
        addr = 32'h0000_1008; #1;
        chk("hit_1008", {31'd0, cache_hit}, 32'd1);
        chk("instr_1008", instr, 32'h33333333);
        addr = 32'h0000_1000; #1;
        chk("instr_1000", instr, 32'h11111111);
        addr = 32'h0000_100C; #1;
        chk("instr_100c", instr, 32'h44444444);
        addr = 32'h0000_1007; #1;
        chk("instr_1007", instr, 32'h22222222);

        // FIFO replacement: fill three more, then 0x5000 evicts 0x1000
        fill(32'h0000_2000, mk_line(32'hA000_0000));
        fill(32'h0000_3000, mk_line(32'hB000_0000));
        fill(32'h0000_4000, mk_line(32'hC000_0000));
        addr = 32'h0000_1004; #1;
        chk("full_hit_1004", instr, 32'h22222222);
        addr = 32'h0000_3008; #1;
        chk("full_instr_3008", instr, 32'hB000_0002);
        fill(32'h0000_5000, mk_line(32'hD000_0000));
        addr = 32'h0000_1000; #1;
        chk("evict_1000", {31'd0, cache_hit}, 32'd0);
        chk("evict_instr", instr, 32'd0);
        addr = 32'h0000_2004; #1;
        chk("keep_2000", {31'd0, cache_hit}, 32'd1);
        chk("keep_instr", instr, 32'hA000_0001);
        addr = 32'h0000_500C; #1;
        chk("new_5000", instr, 32'hD000_0003);

        // Stalled fetch: no request while wrt_en=0
        addr   = 32'h0000_6000;
        wrt_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_no_req", {31'd0, reqI_mem}, 32'd0);
        end
        wrt_en = 1'b1;
        step();
        chk("stall_release_req", {31'd0, reqI_mem}, 32'd1);
        chk("stall_release_addr", {4'd0, reqAddrI_mem}, 32'h0000_0600);

        // Reset in REQ with mem_data_rdy: refill aborted
        wrt_en       = 1'b0;
        reset        = 1'b1;
        mem_data_rdy = 1'b1;
        data_to_fill = mk_line(32'hE000_0000);
        step();
        reset        = 1'b0;
        mem_data_rdy = 1'b0;
        #1;
        chk("abort_req", {31'd0, reqI_mem}, 32'd0);
        chk("abort_req_addr", {4'd0, reqAddrI_mem}, 32'd0);
        chk("abort_miss", {31'd0, cache_hit}, 32'd0);
        chk("abort_instr", instr, 32'd0);
        addr = 32'h0000_2000; #1;
        chk("abort_valid_clr", {31'd0, cache_hit}, 32'd0);
        // Back in IDLE: a new miss issues immediately
        addr   = 32'h0000_6000;
        wrt_en = 1'b1;
        step();
        chk("abort_idle_req", {31'd0, reqI_mem}, 32'd1);

`ifdef ICACHE_PERF_EN
        reset  = 1'b1;
        wrt_en = 1'b0;
        step();
        reset = 1'b0;
        #1;
        chk("perf_rst_hits", hit_count, 32'd0);
        chk("perf_rst_miss", miss_count, 32'd0);
        fill(32'h0000_7000, mk_line(32'hF000_0000));
        addr   = 32'h0000_7004;
        wrt_en = 1'b1;
        for (int i = 0; i < 3; i++) step();
        wrt_en = 1'b0;
        step();
        chk("perf_hits", hit_count, 32'd3);
        chk("perf_miss", miss_count, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
